// File: rtl/uart_pkg.sv
// Shared types and constants for the UART output path.
package uart_pkg;

  localparam int PIX_W               = 8;
  localparam int BUSY_TIMEOUT        = 4;
  localparam int BUSY_CNT_W          = $clog2(BUSY_TIMEOUT);
  localparam int DEFAULT_FRAME_BYTES = 16384;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers, occupancy count, full/empty flags
// and a sticky overflow flag for writes that had nowhere to go.
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q, overflow_q;
  logic              push, pop;

  assign pop  = rd_en_i && !empty_q;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push = wr_en_i && (!full_q || pop);

  // NOTE: every path starts from a default, so no latch can be inferred.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
      if (wr_en_i && !push) overflow_q <= 1'b1;
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/tx_pixel_sender.sv
// Drains buffered filtered pixels into the UART transmitter one byte at a time
// and counts completed bytes per frame.
module tx_pixel_sender
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int FRAME_BYTES = DEFAULT_FRAME_BYTES,
  parameter int CNT_W       = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             tx_ready,
  output logic             tx_start,
  output logic [PIX_W-1:0] tx_data,
  output logic             fifo_full,
  output logic             overflow,
  output logic [CNT_W-1:0] bytes_sent,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [BUSY_CNT_W-1:0] BUSY_LAST = BUSY_CNT_W'(BUSY_TIMEOUT - 1);

  tx_state_t             state_q, state_d;
  logic [BUSY_CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [PIX_W-1:0]      tx_data_q, fifo_head;
  logic [CNT_W-1:0]      bytes_q;
  logic                  frame_done_q;
  logic                  pop, byte_done, fifo_empty;

  sync_fifo #(
    .WIDTH  (PIX_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (pix_valid),
    .wr_data_i  (pix_in),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .overflow_o (overflow)
  );

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = '0;
    pop        = 1'b0;
    tx_start   = 1'b0;
    byte_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && tx_ready) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      // The request is held back if the transmitter went busy, so it never meets tx_ready=0.
      START: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          state_d  = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        busy_cnt_d = busy_cnt_q + 1'b1;
        if (!tx_ready || busy_cnt_q == BUSY_LAST) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          byte_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_cnt_q   <= '0;
      tx_data_q    <= '0;
      bytes_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_cnt_q   <= busy_cnt_d;
      frame_done_q <= byte_done && (bytes_q == LAST_BYTE);
      if (pop)       tx_data_q <= fifo_head;
      if (byte_done) bytes_q   <= (bytes_q == LAST_BYTE) ? '0 : bytes_q + 1'b1;
    end
  end

  assign tx_data    = tx_data_q;
  assign bytes_sent = bytes_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/tx_pixel_sender.md
# tx_pixel_sender

Output-side stage between the kernel filter (`sys_array`) and the UART `transmitter`. It buffers filtered pixels in a small synchronous FIFO and drains them one byte at a time through the transmitter's `start`/`tx_ready` handshake. It counts bytes sent per frame and flags frame completion. All logic runs in the UART clock domain (`uart_clk` at the top level), so pixels never collide with a busy transmitter.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `FRAME_BYTES`, 16384: bytes per frame (128×128 image).
- `CNT_W`, 15: width of the byte counter; must satisfy 2^`CNT_W` > `FRAME_BYTES`.

Ports:
- `clk`  in  1  single clock, driven by `uart_clk`.
- `rst`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `pix_in`  in  8  filtered pixel from the kernel stage.
- `pix_valid`  in  1  `pix_in` valid this cycle; one write per high cycle.
- `tx_ready`  in  1  transmitter idle/buffer available.
- `tx_start`  out  1  one-cycle request to transmit `tx_data`.
- `tx_data`  out  8  byte to transmit; held stable from `tx_start` until the transmitter returns ready.
- `fifo_full`  out  1  FIFO holds `DEPTH` entries.
- `overflow`  out  1  sticky; a write was dropped.
- `bytes_sent`  out  `CNT_W`  bytes completed in the current frame.
- `frame_done`  out  1  one-cycle pulse when the last byte of a frame completes.

## Operation
- Reset values: `tx_start`=0, `tx_data`=0, `fifo_full`=0, `overflow`=0, `bytes_sent`=0, `frame_done`=0, FIFO empty, state IDLE.
- **FIFO.** The FIFO has registered read and write pointers and an `ADDR_W`+1-bit occupancy count; pointers wrap modulo `DEPTH`.
  - Write is accepted when `pix_valid` is high and either count < `DEPTH` or a pop occurs in the same cycle.
  - A write while full with no pop is dropped and sets `overflow`. `overflow` clears only on `rst`.
  - A simultaneous push and pop leaves count unchanged.
- **FSM states:**
  - IDLE: if FIFO is non-empty and `tx_ready`=1, pop the head into `tx_data` and go to START. Otherwise stay.
  - START: `tx_start`=1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for `tx_ready`=0, then go to WAIT_DONE. If `tx_ready` is still 1 after 4 cycles, treat the byte as accepted and go to WAIT_DONE.
  - WAIT_DONE: wait for `tx_ready`=1. On that cycle, increment `bytes_sent` and return to IDLE.
- **Frame counter.** When the increment would reach `FRAME_BYTES`, `bytes_sent` wraps to 0 and `frame_done` pulses in the same cycle. Arithmetic is unsigned `CNT_W`-bit.
- **Reset mid-byte.** `rst` aborts the FSM to IDLE and discards FIFO contents. Any byte already handed to the transmitter is not counted.
- `tx_start` is never asserted while `tx_ready`=0.

## Timing
- Empty FIFO, IDLE, `tx_ready`=1: with `pix_valid` high in cycle n, `tx_start` is high in cycle n+2 and `tx_data` is valid from n+2.
- Back-to-back bytes: the next `tx_start` comes no earlier than 2 cycles after `tx_ready` returns high (increment in WAIT_DONE, pop in IDLE, pulse in START).
- `fifo_full` is registered and reflects the count after the current cycle's push/pop.
- `frame_done` and the `bytes_sent` update occur on the same edge.

## Structure
- Package `uart_pkg`:
  - state enum `tx_state_t` {IDLE, START, WAIT_BUSY, WAIT_DONE};
  - constants `PIX_W`=8 and `BUSY_TIMEOUT`=4;
  - default `FRAME_BYTES`.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`, `ADDR_W`) holds storage, pointers, count, full/empty and overflow. The top level holds the FSM and frame counter.

## Test plan
- Single byte: push 0xA5 into an idle block with `tx_ready`=1. `tx_start` pulses 2 cycles later with `tx_data`=0xA5. Model drops `tx_ready` for 10 cycles. `bytes_sent`=1 after `tx_ready` rises.
- Burst fill: push 16 bytes 0x00..0x0F on consecutive cycles while `tx_ready`=0. `fifo_full`=1 and `overflow`=0. A 17th push sets `overflow`=1. Releasing `tx_ready` transmits 0x00..0x0F in order.
- Full with simultaneous pop: full FIFO, `pix_valid` in the same cycle as the IDLE pop. The write is accepted, count stays 16, `overflow` stays 0.
- Frame wrap: with `FRAME_BYTES`=4, send 4 bytes. `frame_done` pulses once as `bytes_sent` goes 3→0. The 5th byte gives `bytes_sent`=1.
- Busy timeout: a transmitter model that never drops `tx_ready`. The FSM leaves WAIT_BUSY after 4 cycles, and each byte is counted exactly once.
- Reset mid-byte: assert `rst` during WAIT_DONE with 5 bytes queued. The next cycle shows all outputs at reset values and the FIFO empty, with no further `tx_start`.
